prog_loader: RTL and testbench

Program loader for the multi-cycle `CPU`, placed directly upstream of its `load`/`ins`/`start` port group. It accepts an instruction stream from a host source over a valid/ready handshake and replays it into the CPU as one-word-per-cycle `load` strobes. After the last word it waits a fixed gap, then raises `start` and holds it. This replaces bench-driven loading and lets the CPU be booted from any streaming source.

---
 rtl/prog_loader_pkg.sv | 5 +
 rtl/prog_loader.sv | 81 ++++++++
 tb/tb_prog_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and gap-counter width for the program loader.
package prog_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_RUN, S_ERR} state_t;
    localparam int GAP_W = 4;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams a host program into the CPU as load strobes, then raises start after a fixed gap.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int START_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic                       host_valid,
    input  logic [DATA_W-1:0]          host_data,
    input  logic                       host_last,
    output logic                       host_ready,
    output logic                       load,
    output logic [DATA_W-1:0]          ins,
    output logic                       start,
    output logic                       busy,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] word_count
);
    localparam int CW = $clog2(DEPTH+1);

    state_t           r_state;
    logic [GAP_W-1:0] r_gap;
    logic             w_acc;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_acc     = host_valid && host_ready;
    assign w_cnt_nxt = word_count + 1'b1;

    // Outputs are updated alongside the state so each reflects the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gap      <= '0;
            host_ready <= 1'b0;
            load       <= 1'b0;
            ins        <= '0;
            start      <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            load <= 1'b0;
            case (r_state)
                S_IDLE: if (go) begin
                    r_state    <= S_LOAD;
                    word_count <= '0;
                    host_ready <= 1'b1;
                    busy       <= 1'b1;
                end
                S_LOAD: if (w_acc) begin
                    ins        <= host_data;
                    load       <= 1'b1;
                    word_count <= w_cnt_nxt;
                    if (host_last) begin
                        r_state    <= S_GAP;
                        r_gap      <= GAP_W'(START_GAP);
                        host_ready <= 1'b0;
                    end else if (w_cnt_nxt == CW'(DEPTH)) begin
                        r_state    <= S_ERR;
                        host_ready <= 1'b0;
                        busy       <= 1'b0;
                        err        <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 1'b1;
                    if (r_gap == GAP_W'(1)) begin
                        r_state <= S_RUN;
                        busy    <= 1'b0;
                        start   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed table and sequence checks of prog_loader at DEPTH=128 and DEPTH=4.
module tb_prog_loader;
    localparam int GAP_B = 2;
    localparam int GAP_S = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go_b = 1'b0, go_s = 1'b0;
    logic        host_valid = 1'b0, host_last = 1'b0;
    logic [31:0] host_data = '0;

    logic        ready_b, load_b, start_b, busy_b, err_b;
    logic [31:0] ins_b;
    logic [7:0]  wc_b;
    logic        ready_s, load_s, start_s, busy_s, err_s;
    logic [31:0] ins_s;
    logic [2:0]  wc_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_loader #(.DATA_W(32), .DEPTH(128), .START_GAP(GAP_B)) u_big (
        .clk(clk), .rst(rst), .go(go_b), .host_valid(host_valid), .host_data(host_data),
        .host_last(host_last), .host_ready(ready_b), .load(load_b), .ins(ins_b),
        .start(start_b), .busy(busy_b), .err(err_b), .word_count(wc_b)
    );

    prog_loader #(.DATA_W(32), .DEPTH(4), .START_GAP(GAP_S)) u_small (
        .clk(clk), .rst(rst), .go(go_s), .host_valid(host_valid), .host_data(host_data),
        .host_last(host_last), .host_ready(ready_s), .load(load_s), .ins(ins_s),
        .start(start_s), .busy(busy_s), .err(err_s), .word_count(wc_s)
    );

    typedef struct {
        logic        go, valid;
        logic [31:0] data;
        logic        last;
        logic        e_ready, e_load;
        logic [31:0] e_ins;
        logic        e_start, e_busy, e_err;
        logic [7:0]  e_wc;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int i);
        return 32'h1234_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic do_reset();
        rst = 1'b1; go_b = 1'b0; go_s = 1'b0;
        host_valid = 1'b0; host_last = 1'b0; host_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic run_prog(input int n, input int hole, input int go_at);
        int sent = 0;
        int cyc = 0;
        logic [31:0] ei = '0;
        logic acc;
        go_b = 1'b1; tick(); go_b = 1'b0;
        chk("ready_after_go", 64'(ready_b), 64'd1);
        while (sent < n && cyc < 4 * n + 10) begin
            acc = !(hole != 0 && cyc % hole == hole - 1);
            host_valid = acc;
            host_data  = wd(sent);
            host_last  = (sent == n - 1);
            go_b       = (go_at != 0 && cyc == go_at);
            tick();
            if (acc) begin
                ei = wd(sent);
                sent++;
            end
            chk("load", 64'(load_b), 64'(acc));
            chk("ins", 64'(ins_b), 64'(ei));
            chk("word_count", 64'(wc_b), 64'(sent));
            if (sent < n) chk("ready_in_load", 64'(ready_b), 64'd1);
            cyc++;
        end
        go_b = 1'b0; host_valid = 1'b0; host_last = 1'b0;
        chk("words_sent", 64'(sent), 64'(n));
        chk("gap_entry rdy/busy/start/err", 64'({ready_b, busy_b, start_b, err_b}), 64'b0100);
        for (int k = 2; k <= GAP_B; k++) begin
            tick();
            chk("gap load/busy/start", 64'({load_b, busy_b, start_b}), 64'b010);
        end
        tick();
        chk("start_rise load/busy/start", 64'({load_b, busy_b, start_b}), 64'b001);
        chk("final_count", 64'(wc_b), 64'(n));
        go_b = 1'b1; tick(); go_b = 1'b0;
        chk("go_in_run start/busy/rdy", 64'({start_b, busy_b, ready_b}), 64'b100);
        chk("go_in_run count", 64'(wc_b), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b1, 1'b1, 32'hDEAD0001, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[3] = '{1'b0, 1'b1, 32'hBEEF0002, 1'b0, 1'b1, 1'b1, 32'hBEEF0002, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[4] = '{1'b0, 1'b1, 32'hCAFE0003, 1'b1, 1'b0, 1'b1, 32'hCAFE0003, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hCAFE0003, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hCAFE0003, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[7] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hCAFE0003, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[8] = '{1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0, 32'hCAFE0003, 1'b1, 1'b0, 1'b0, 8'd3};

        do_reset();
        chk("reset_big", 64'({ready_b, load_b, ins_b, start_b, busy_b, err_b, wc_b}), 64'd0);
        chk("reset_small", 64'({ready_s, load_s, ins_s, start_s, busy_s, err_s, wc_s}), 64'd0);

        for (int i = 0; i < 9; i++) begin
            go_b = tbl[i].go; host_valid = tbl[i].valid;
            host_data = tbl[i].data; host_last = tbl[i].last;
            tick();
            chk($sformatf("table[%0d]", i),
                64'({ready_b, load_b, ins_b, start_b, busy_b, err_b, wc_b}),
                64'({tbl[i].e_ready, tbl[i].e_load, tbl[i].e_ins, tbl[i].e_start,
                     tbl[i].e_busy, tbl[i].e_err, tbl[i].e_wc}));
        end

        do_reset();
        run_prog(20, 0, 0);

        do_reset();
        run_prog(20, 3, 5);

        // Reset lands mid-load, then a fresh short program must run cleanly.
        do_reset();
        go_b = 1'b1; tick(); go_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            host_valid = 1'b1; host_data = wd(i); tick();
        end
        chk("pre_rst count", 64'(wc_b), 64'd7);
        rst = 1'b1; host_data = wd(7); tick(); rst = 1'b0; host_valid = 1'b0;
        chk("mid_rst outputs", 64'({ready_b, load_b, ins_b, start_b, busy_b, err_b, wc_b}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst idle", 64'({ready_b, start_b, busy_b, load_b}), 64'd0);
        end
        run_prog(3, 0, 0);

        // Overflow: five words without host_last into a 4-deep loader.
        do_reset();
        go_s = 1'b1; tick(); go_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1; host_data = wd(100 + i); host_last = 1'b0;
            tick();
            chk("ovf load", 64'(load_s), 64'(i < 4));
            chk("ovf ins", 64'(ins_s), 64'(wd(i < 4 ? 100 + i : 103)));
            chk("ovf count", 64'(wc_s), 64'(i < 4 ? i + 1 : 4));
        end
        chk("ovf err/rdy/busy/start", 64'({err_s, ready_s, busy_s, start_s}), 64'b1000);
        host_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf hold", 64'({err_s, ready_s, busy_s, start_s, load_s}), 64'b10000);
        end

        // Exactly DEPTH words with host_last is a legal full program.
        do_reset();
        go_s = 1'b1; tick(); go_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1; host_data = wd(200 + i); host_last = (i == 3);
            tick();
            chk("full load/ins", 64'({load_s, ins_s}), 64'({1'b1, wd(200 + i)}));
            chk("full count", 64'(wc_s), 64'(i + 1));
        end
        host_valid = 1'b0; host_last = 1'b0;
        chk("full gap err/rdy/busy/start", 64'({err_s, ready_s, busy_s, start_s}), 64'b0010);
        for (int k = 2; k <= GAP_S; k++) begin
            tick();
            chk("full gap", 64'({err_s, busy_s, start_s}), 64'b010);
        end
        tick();
        chk("full start", 64'({err_s, busy_s, start_s, wc_s}), 64'({3'b001, 3'd4}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
